// File: rtl/ex_trap_arb.sv
// rtl/ex_trap_arb.sv - external interrupt arbiter: per-source pending, fixed priority, single trap handshake
module ex_trap_arb #(
  parameter int SRC_NUM = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src_irq,
  input  logic [SRC_NUM-1:0] cfg_en,
  input  logic [SRC_NUM-1:0] cfg_edge,
  input  logic               trap_done,
  output logic               core_ex_trap_valid,
  input  logic               core_ex_trap_ready,
  output logic [ID_W-1:0]    trap_id,
  output logic               trap_busy,
  output logic [SRC_NUM-1:0] pend
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [SRC_NUM-1:0] prev;
  logic [SRC_NUM-1:0] pend_nxt;
  logic [ID_W-1:0]    win_id;
  logic               claim;

  assign claim = (state == REQ) && core_ex_trap_ready;

  // Descending scan so the lowest pending index is the last assignment and wins.
  always_comb begin
    win_id = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--) begin
      if (pend[i]) win_id = ID_W'(i);
    end
  end

  // A new edge in the claim cycle beats the claim clear, so it is not lost.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (!cfg_en[i]) begin
        pend_nxt[i] = 1'b0;
      end else if (cfg_edge[i]) begin
        if (src_irq[i] && !prev[i]) begin
          pend_nxt[i] = 1'b1;
        end else if (claim && (trap_id == ID_W'(i))) begin
          pend_nxt[i] = 1'b0;
        end else begin
          pend_nxt[i] = pend[i];
        end
      end else begin
        pend_nxt[i] = src_irq[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= src_irq;
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      core_ex_trap_valid <= 1'b0;
      trap_busy          <= 1'b0;
      trap_id            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            trap_id            <= win_id;
            core_ex_trap_valid <= 1'b1;
            state              <= REQ;
          end
        end
        REQ: begin
          if (core_ex_trap_ready) begin
            core_ex_trap_valid <= 1'b0;
            trap_busy          <= 1'b1;
            state              <= SERVICE;
          end
        end
        SERVICE: begin
          if (trap_done) begin
            trap_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state              <= IDLE;
          core_ex_trap_valid <= 1'b0;
          trap_busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_trap_arb.sv
// tb/tb_ex_trap_arb.sv - directed scoreboard bench for ex_trap_arb
module tb_ex_trap_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_irq;
  logic [7:0] cfg_en;
  logic [7:0] cfg_edge;
  logic       trap_done;
  logic       core_ex_trap_valid;
  logic       core_ex_trap_ready;
  logic [2:0] trap_id;
  logic       trap_busy;
  logic [7:0] pend;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  ex_trap_arb #(.SRC_NUM(8), .ID_W(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .src_irq            (src_irq),
    .cfg_en             (cfg_en),
    .cfg_edge           (cfg_edge),
    .trap_done          (trap_done),
    .core_ex_trap_valid (core_ex_trap_valid),
    .core_ex_trap_ready (core_ex_trap_ready),
    .trap_id            (trap_id),
    .trap_busy          (trap_busy),
    .pend               (pend)
  );

  always #5 clk = ~clk;

  task automatic exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "valid": observe = 32'(core_ex_trap_valid);
      "busy":  observe = 32'(trap_busy);
      "id":    observe = 32'(trap_id);
      "pend":  observe = 32'(pend);
      default: observe = 'x;
    endcase
  endfunction

  // One clock, then compare everything expected for the state after that edge.
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.tag);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; src_irq = '0; cfg_en = '0; cfg_edge = '0;
    trap_done = 1'b0; core_ex_trap_ready = 1'b0;
    step(); step();
    exp("valid", 0); exp("busy", 0); exp("id", 0); exp("pend", 0); step();

    // single edge source on bit 3
    rst = 1'b0; cfg_en = 8'h08; cfg_edge = 8'h08; step();
    src_irq = 8'h08; exp("pend", 8'h08); exp("valid", 0); step();
    src_irq = 8'h00; exp("valid", 1); exp("id", 3); step();
    core_ex_trap_ready = 1'b1; exp("valid", 0); exp("busy", 1); exp("pend", 0); step();
    core_ex_trap_ready = 1'b0; step(); step();
    trap_done = 1'b1; exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 0); step();
    exp("valid", 0); step();

    // fixed priority: bits 2 and 5 together
    cfg_en = 8'hFF; cfg_edge = 8'hFF; step();
    src_irq = 8'h24; exp("pend", 8'h24); step();
    src_irq = 8'h00; exp("valid", 1); exp("id", 2); step();
    core_ex_trap_ready = 1'b1; exp("busy", 1); exp("pend", 8'h20); exp("id", 2); step();
    trap_done = 1'b1; exp("busy", 0); exp("valid", 0); step();
    trap_done = 1'b0; exp("valid", 1); exp("id", 5); step();
    exp("valid", 0); exp("busy", 1); exp("pend", 8'h00); step();
    core_ex_trap_ready = 1'b0; trap_done = 1'b1; exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 0); step();

    // backpressure with a level source dropping mid-request
    cfg_edge = 8'h00; src_irq = 8'h02; exp("pend", 8'h02); step();
    exp("valid", 1); exp("id", 1); step();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) src_irq = 8'h00;
      exp("valid", 1); exp("id", 1); step();
    end
    exp("pend", 8'h00);
    core_ex_trap_ready = 1'b1; exp("valid", 0); exp("busy", 1); step();
    core_ex_trap_ready = 1'b0; trap_done = 1'b1; exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 0); step();
    exp("valid", 0); step();

    // level re-request while the line stays high through done
    src_irq = 8'h01; exp("pend", 8'h01); step();
    exp("valid", 1); exp("id", 0); step();
    core_ex_trap_ready = 1'b1; exp("busy", 1); step();
    core_ex_trap_ready = 1'b0; trap_done = 1'b1; exp("busy", 0); exp("valid", 0); step();
    trap_done = 1'b0; exp("valid", 1); exp("id", 0); step();
    core_ex_trap_ready = 1'b1; exp("busy", 1); step();
    core_ex_trap_ready = 1'b0; src_irq = 8'h00; exp("pend", 8'h00); step();
    trap_done = 1'b1; exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 0); step();
    exp("valid", 0); exp("pend", 8'h00); step();

    // masked source toggling, done in IDLE ignored
    cfg_en = 8'hEF; cfg_edge = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      src_irq = k[0] ? 8'h00 : 8'h10;
      exp("pend", 8'h00); exp("valid", 0); step();
    end
    src_irq = 8'h00; trap_done = 1'b1; exp("valid", 0); exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 0); step();

    // bit 6: edge coinciding with the claim, then an edge during service
    src_irq = 8'h40; exp("pend", 8'h40); step();
    src_irq = 8'h00; exp("valid", 1); exp("id", 6); step();
    src_irq = 8'h40; core_ex_trap_ready = 1'b1;
    exp("busy", 1); exp("valid", 0); exp("pend", 8'h40); step();
    src_irq = 8'h00; core_ex_trap_ready = 1'b0; exp("pend", 8'h40); exp("busy", 1); step();
    trap_done = 1'b1; exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 1); exp("id", 6); step();
    core_ex_trap_ready = 1'b1; exp("busy", 1); exp("pend", 8'h00); step();
    core_ex_trap_ready = 1'b0; src_irq = 8'h40; exp("pend", 8'h40); exp("busy", 1); exp("id", 6); step();
    src_irq = 8'h00; trap_done = 1'b1; exp("busy", 0); step();
    trap_done = 1'b0; exp("valid", 1); exp("id", 6); step();
    core_ex_trap_ready = 1'b1; exp("busy", 1); step();
    core_ex_trap_ready = 1'b0; trap_done = 1'b1; exp("busy", 0); exp("pend", 8'h00); step();
    trap_done = 1'b0; step();

    // reset during REQ
    cfg_en = 8'hFF; cfg_edge = 8'hFF;
    src_irq = 8'h20; exp("pend", 8'h20); step();
    src_irq = 8'h00; exp("valid", 1); exp("id", 5); step();
    rst = 1'b1; exp("valid", 0); exp("busy", 0); exp("id", 0); exp("pend", 0); step();
    rst = 1'b0; exp("valid", 0); step();

    // reset during SERVICE with another source pending
    src_irq = 8'h20; step();
    src_irq = 8'h00; exp("valid", 1); exp("id", 5); step();
    core_ex_trap_ready = 1'b1; exp("busy", 1); step();
    core_ex_trap_ready = 1'b0; src_irq = 8'h08; exp("pend", 8'h08); step();
    rst = 1'b1; src_irq = 8'h00;
    exp("valid", 0); exp("busy", 0); exp("id", 0); exp("pend", 0); step();
    rst = 1'b0; exp("valid", 0); exp("pend", 0); step();
    exp("valid", 0); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
